// File: rtl/sram_mem_ctrl_pkg.sv
// rtl/sram_mem_ctrl_pkg.sv - shared types and constants for the LC-3 SRAM access controller
package lc3_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_IO,
        ST_DONE,
        ST_HOLD
    } mem_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } mem_op_t;

    localparam logic [15:0] DEFAULT_IO_ADDR = 16'hFFFF;
    localparam int          SRAM_ADDR_W     = 20;

endpackage

// File: rtl/sram_mem_ctrl_if.sv
// rtl/sram_mem_ctrl_if.sv - CPU request/response and SRAM pin bundle
interface sram_mem_ctrl_if;
    import lc3_mem_pkg::*;

    logic                   Mem_OE;
    logic                   Mem_WE;
    logic [15:0]            MAR;
    logic [15:0]            MDR;
    logic [15:0]            Data_to_CPU;
    logic                   Mem_Ready;
    logic                   Busy;
    logic [SRAM_ADDR_W-1:0] SRAM_ADDR;
    logic                   SRAM_CE_N;
    logic                   SRAM_OE_N;
    logic                   SRAM_WE_N;
    logic                   SRAM_UB_N;
    logic                   SRAM_LB_N;
    logic [15:0]            SRAM_DQ_in;
    logic [15:0]            SRAM_DQ_out;
    logic                   SRAM_DQ_oe;

    modport master (
        output Mem_OE, Mem_WE, MAR, MDR, SRAM_DQ_in,
        input  Data_to_CPU, Mem_Ready, Busy, SRAM_ADDR, SRAM_CE_N, SRAM_OE_N,
               SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_DQ_out, SRAM_DQ_oe
    );

    modport slave (
        input  Mem_OE, Mem_WE, MAR, MDR, SRAM_DQ_in,
        output Data_to_CPU, Mem_Ready, Busy, SRAM_ADDR, SRAM_CE_N, SRAM_OE_N,
               SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_DQ_out, SRAM_DQ_oe
    );

endinterface

// File: rtl/sram_mem_ctrl_mmio_regs.sv
// rtl/sram_mem_ctrl_mmio_regs.sv - hex display register and switch read mux for the I/O address
module mmio_regs (
    input  logic        clk,
    input  logic        reset,
    input  logic        hex_load,
    input  logic [15:0] hex_wdata,
    input  logic        rd_sel,
    input  logic [15:0] switches,
    output logic [15:0] hex_data,
    output logic [15:0] rd_data
);

    logic [15:0] hex_q;
    logic [15:0] hex_d;

    always_comb begin
        hex_d = hex_q;
        if (hex_load) begin
            hex_d = hex_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hex_q <= 16'h0000;
        end else begin
            hex_q <= hex_d;
        end
    end

    assign hex_data = hex_q;
    assign rd_data  = rd_sel ? switches : 16'h0000;

endmodule

// File: rtl/sram_mem_ctrl.sv
// rtl/sram_mem_ctrl.sv - turns level-held LC-3 memory requests into timed active-low SRAM cycles
module sram_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] IO_ADDR     = DEFAULT_IO_ADDR
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [15:0]     Switches,
    output logic [15:0]     HEX_Data,
    sram_mem_ctrl_if.slave  bus
);

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    mem_state_t  state_q, state_d;
    mem_op_t     op_q, op_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;

    logic        hex_load;
    logic        io_rd_sel;
    logic [15:0] io_rdata;
    logic        in_access;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        hex_load  = 1'b0;
        io_rd_sel = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Write wins when both requests arrive together
                if (bus.Mem_WE || bus.Mem_OE) begin
                    op_d    = bus.Mem_WE ? OP_WRITE : OP_READ;
                    addr_d  = bus.MAR;
                    cnt_d   = 4'd0;
                    state_d = (bus.MAR == IO_ADDR) ? ST_IO : ST_ACCESS;
                    if (bus.Mem_WE) begin
                        wdata_d = bus.MDR;
                    end
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = 4'd0;
                    state_d = ST_DONE;
                    if (op_q == OP_READ) begin
                        rdata_d = bus.SRAM_DQ_in;
                    end
                end
            end
            ST_IO: begin
                state_d = ST_DONE;
                if (op_q == OP_READ) begin
                    io_rd_sel = 1'b1;
                    rdata_d   = io_rdata;
                end else begin
                    hex_load = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                // A still-held request must not start a second access
                if (!bus.Mem_OE && !bus.Mem_WE) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_READ;
            cnt_q   <= 4'd0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    mmio_regs u_mmio_regs (
        .clk       (Clk),
        .reset     (Reset),
        .hex_load  (hex_load),
        .hex_wdata (wdata_q),
        .rd_sel    (io_rd_sel),
        .switches  (Switches),
        .hex_data  (HEX_Data),
        .rd_data   (io_rdata)
    );

    // Pins decode only registered state and latches, so no request-to-pin path exists
    assign in_access       = (state_q == ST_ACCESS);
    assign bus.SRAM_CE_N   = ~in_access;
    assign bus.SRAM_UB_N   = ~in_access;
    assign bus.SRAM_LB_N   = ~in_access;
    assign bus.SRAM_OE_N   = ~(in_access && (op_q == OP_READ));
    assign bus.SRAM_WE_N   = ~(in_access && (op_q == OP_WRITE));
    assign bus.SRAM_DQ_oe  = in_access && (op_q == OP_WRITE);
    assign bus.SRAM_ADDR   = {{(SRAM_ADDR_W-16){1'b0}}, addr_q};
    assign bus.SRAM_DQ_out = wdata_q;
    assign bus.Data_to_CPU = rdata_q;
    assign bus.Mem_Ready   = (state_q == ST_DONE);
    assign bus.Busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb/tb_sram_mem_ctrl.sv - directed bench with a read-data scoreboard for sram_mem_ctrl
module tb_sram_mem_ctrl;

    localparam int W = 2;

    logic        Clk;
    logic        Reset;
    logic [15:0] Switches;
    logic [15:0] HEX_Data;

    sram_mem_ctrl_if bus();

    sram_mem_ctrl #(.WAIT_CYCLES(W), .IO_ADDR(16'hFFFF)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Switches (Switches),
        .HEX_Data (HEX_Data),
        .bus      (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // SRAM device model, 256 words
    logic [15:0] sram [0:255];
    logic        pl_en;
    logic [7:0]  pl_a;
    logic [15:0] pl_d;

    always @(posedge Clk) begin
        if (pl_en) begin
            sram[pl_a] <= pl_d;
        end else if (!bus.SRAM_CE_N && !bus.SRAM_WE_N && bus.SRAM_DQ_oe) begin
            sram[bus.SRAM_ADDR[7:0]] <= bus.SRAM_DQ_out;
        end
    end

    assign bus.SRAM_DQ_in = (!bus.SRAM_CE_N && !bus.SRAM_OE_N) ? sram[bus.SRAM_ADDR[7:0]] : 16'hDEAD;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_mem [0:255];
    logic [15:0] exp_q [$];
    int oe_lo, we_lo, dqoe_n, rdy_n, rdy_at, any_strobe, addr_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        @(negedge Clk);
        pl_en = 1'b1; pl_a = a; pl_d = d;
        exp_mem[a] = d;
        @(negedge Clk);
        pl_en = 1'b0;
    endtask

    task automatic run_access(input logic we, input logic oe, input logic [15:0] mar,
                              input logic [15:0] mdr, input int hold, input int ncyc,
                              input int chg_at);
        logic [19:0] exp_addr;
        logic [15:0] popped;
        exp_addr = {4'h0, mar};
        oe_lo = 0; we_lo = 0; dqoe_n = 0; rdy_n = 0; rdy_at = -1; any_strobe = 0; addr_bad = 0;
        if (oe && !we) begin
            exp_q.push_back((mar == 16'hFFFF) ? Switches : exp_mem[mar[7:0]]);
        end else if (we && mar != 16'hFFFF) begin
            exp_mem[mar[7:0]] = mdr;
        end
        @(negedge Clk);
        bus.Mem_WE = we; bus.Mem_OE = oe; bus.MAR = mar; bus.MDR = mdr;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge Clk); #1;
            if (!bus.SRAM_OE_N) oe_lo++;
            if (!bus.SRAM_WE_N) we_lo++;
            if (bus.SRAM_DQ_oe) dqoe_n++;
            if (!bus.SRAM_CE_N || !bus.SRAM_OE_N || !bus.SRAM_WE_N || !bus.SRAM_UB_N || !bus.SRAM_LB_N)
                any_strobe++;
            if (!bus.SRAM_CE_N && bus.SRAM_ADDR !== exp_addr) addr_bad++;
            if (!bus.SRAM_WE_N && bus.SRAM_DQ_out !== mdr) addr_bad++;
            if (bus.Mem_Ready) begin
                rdy_n++;
                if (rdy_at < 0) rdy_at = k;
                if (oe && !we) begin
                    if (exp_q.size() == 0) begin
                        check("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        popped = exp_q.pop_front();
                        check("rd_data", {16'h0, bus.Data_to_CPU}, {16'h0, popped});
                    end
                end
            end
            if (k == chg_at) bus.MAR = 16'h00AA;
            if (k == hold) begin bus.Mem_OE = 1'b0; bus.Mem_WE = 1'b0; end
        end
    endtask

    initial begin
        Reset = 1'b1; Switches = 16'h0000; pl_en = 1'b0; pl_a = 8'h00; pl_d = 16'h0000;
        bus.Mem_OE = 1'b0; bus.Mem_WE = 1'b0; bus.MAR = 16'h0000; bus.MDR = 16'h0000;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_busy", {31'h0, bus.Busy}, 32'd0);
        check("rst_ce_n", {31'h0, bus.SRAM_CE_N}, 32'd1);
        check("rst_ready", {31'h0, bus.Mem_Ready}, 32'd0);
        check("rst_data", {16'h0, bus.Data_to_CPU}, 32'd0);
        check("rst_hex", {16'h0, HEX_Data}, 32'd0);
        check("rst_dq_oe", {31'h0, bus.SRAM_DQ_oe}, 32'd0);
        @(negedge Clk); Reset = 1'b0;

        preload(8'h30, 16'h1234);
        preload(8'hAA, 16'h0AAA);

        // SRAM read, request held 5 cycles
        run_access(1'b0, 1'b1, 16'h0030, 16'h0000, 5, 10, 0);
        check("rd_oe_cycles", oe_lo, W);
        check("rd_ready_cnt", rdy_n, 1);
        check("rd_ready_at", rdy_at, W + 1);

        // SRAM write then read back
        run_access(1'b1, 1'b0, 16'h0041, 16'hBEEF, 4, 8, 0);
        check("wr_we_cycles", we_lo, W);
        check("wr_dqoe_cycles", dqoe_n, W);
        check("wr_addr_bad", addr_bad, 0);
        check("wr_ready_at", rdy_at, W + 1);
        run_access(1'b0, 1'b1, 16'h0041, 16'h0000, 4, 8, 0);
        check("rb_ready_cnt", rdy_n, 1);

        // I/O write
        run_access(1'b1, 1'b0, 16'hFFFF, 16'h00A5, 3, 6, 0);
        check("io_hex", {16'h0, HEX_Data}, 32'h00A5);
        check("io_wr_strobes", any_strobe, 0);
        check("io_wr_ready_at", rdy_at, 2);

        // I/O read of switches
        Switches = 16'h0F0F;
        run_access(1'b0, 1'b1, 16'hFFFF, 16'h0000, 3, 6, 0);
        check("io_rd_oe", oe_lo, 0);
        check("io_rd_ready_at", rdy_at, 2);
        check("io_rd_data_hold", {16'h0, bus.Data_to_CPU}, 32'h0F0F);

        // Simultaneous request performs a write
        run_access(1'b1, 1'b1, 16'h0050, 16'h5A5A, 4, 8, 0);
        check("both_we", we_lo, W);
        check("both_oe", oe_lo, 0);
        check("both_data_kept", {16'h0, bus.Data_to_CPU}, 32'h0F0F);
        run_access(1'b0, 1'b1, 16'h0050, 16'h0000, 4, 8, 0);

        // MAR changed during ACCESS
        run_access(1'b1, 1'b0, 16'h0060, 16'h6161, 4, 8, 1);
        check("chg_addr_bad", addr_bad, 0);
        run_access(1'b0, 1'b1, 16'h0060, 16'h0000, 4, 8, 0);
        run_access(1'b0, 1'b1, 16'h00AA, 16'h0000, 4, 8, 0);
        check("hex_unchanged", {16'h0, HEX_Data}, 32'h00A5);

        // Reset in the second ACCESS cycle
        @(negedge Clk);
        bus.Mem_OE = 1'b1; bus.MAR = 16'h0030;
        @(posedge Clk); #1;
        check("rst_mid_first", {31'h0, bus.SRAM_CE_N}, 32'd0);
        @(posedge Clk); #1;
        Reset = 1'b1; bus.Mem_OE = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b0;
        check("rst_mid_strobes", {27'h0, bus.SRAM_CE_N, bus.SRAM_OE_N, bus.SRAM_WE_N,
                                  bus.SRAM_UB_N, bus.SRAM_LB_N}, 32'h1F);
        check("rst_mid_busy", {31'h0, bus.Busy}, 32'd0);
        check("rst_mid_hex", {16'h0, HEX_Data}, 32'd0);
        rdy_n = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.Mem_Ready) rdy_n++;
            @(posedge Clk); #1;
        end
        check("rst_mid_no_ready", rdy_n, 0);
        check("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
